// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package divider_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITER    = 2'd1,
    CORRECT = 2'd2,
    DONE    = 2'd3
  } div_state_t;

endpackage

// File: rtl/divider_fsm.sv
// Control FSM for booth_divider_seq.
// Owns the state register, the iteration counter and the in/out handshakes.
// It also produces the datapath strobes load, step, correct and hold.
module divider_fsm
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_in_valid,
  input  logic i_div_zero,
  input  logic i_out_ready,
  output logic o_in_ready,
  output logic o_out_valid,
  output logic o_busy,
  output logic o_load,
  output logic o_step,
  output logic o_correct,
  output logic o_hold
);

  localparam int unsigned CntW = $clog2(WIDTH);

  div_state_t      r_state;
  logic [CntW-1:0] r_count;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (i_div_zero) begin
              // No iterations; out_valid follows one cycle after entering DONE.
              r_state <= DONE;
            end else begin
              r_state <= ITER;
              r_count <= CntW'(WIDTH - 1);
            end
          end
        end
        ITER: begin
          if (r_count == '0) begin
            r_state <= CORRECT;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        CORRECT: begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
        end
        DONE: begin
          if (r_out_valid && i_out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  // in_ready is only ever high in IDLE, so the accept strobe needs no state decode.
  assign o_load      = i_in_valid && r_in_ready;
  assign o_step      = (r_state == ITER);
  assign o_correct   = (r_state == CORRECT);
  assign o_hold      = (r_state == DONE);

endmodule

// File: rtl/booth_divider_seq.sv
// Sequential radix-2 non-restoring divider, one quotient bit per cycle.
// Optional feature macro: SIGNED_DIV_EN (two's complement operands, truncating division).
// Without the macro the operands are unsigned and no sign logic exists.
module booth_divider_seq
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  logic w_load;
  logic w_step;
  logic w_correct;
  logic w_hold;
  logic w_div_zero;

  assign w_div_zero = (divisor == '0);

  divider_fsm #(
    .WIDTH (WIDTH)
  ) u_fsm (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_in_valid  (in_valid),
    .i_div_zero  (w_div_zero),
    .i_out_ready (out_ready),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_busy      (busy),
    .o_load      (w_load),
    .o_step      (w_step),
    .o_correct   (w_correct),
    .o_hold      (w_hold)
  );

  // Operand magnitudes fed into the unsigned core.
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;

`ifdef SIGNED_DIV_EN
  logic w_dvd_neg;
  logic w_dvs_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_dvd_neg = dividend[WIDTH-1];
  assign w_dvs_neg = divisor[WIDTH-1];
  // -MIN wraps to MIN, which is still the right magnitude when read as unsigned.
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor : divisor;
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
`endif

  // P carries one extra bit so its sign survives the add/sub step.
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_d;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_p_sh;
  logic [WIDTH:0]   w_p_new;
  logic [WIDTH-1:0] w_q_new;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_p_sh  = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_p_new = r_p[WIDTH] ? (w_p_sh + r_d) : (w_p_sh - r_d);
  assign w_q_new = {r_q[WIDTH-2:0], ~w_p_new[WIDTH]};
  // Final restore of a negative partial remainder; only the low WIDTH bits are kept.
  assign w_rem_mag = r_p[WIDTH] ? (r_p[WIDTH-1:0] + r_d[WIDTH-1:0]) : r_p[WIDTH-1:0];

`ifdef SIGNED_DIV_EN
  assign w_quot_fix = r_neg_q ? -r_q : r_q;
  assign w_rem_fix  = r_neg_r ? -w_rem_mag : w_rem_mag;
`else
  assign w_quot_fix = r_q;
  assign w_rem_fix  = w_rem_mag;
`endif

  // Datapath: load operands, iterate, then commit the corrected result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p    <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else if (w_load) begin
      r_p   <= '0;
      r_q   <= w_dvd_mag;
      r_d   <= {1'b0, w_dvs_mag};
      r_dbz <= w_div_zero;
      if (w_div_zero) begin
        r_quot <= '1;
        r_rem  <= dividend;
      end
`ifdef SIGNED_DIV_EN
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
`endif
    end else if (w_step) begin
      r_p <= w_p_new;
      r_q <= w_q_new;
    end else if (w_correct) begin
      r_quot <= w_quot_fix;
      r_rem  <= w_rem_fix;
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

  // Results must not move while the block is holding them in DONE.
  a_hold_stable : assert property (@(posedge clk) disable iff (!reset_n)
      (w_hold && !(out_valid && out_ready)) |=>
      ($stable(quotient) && $stable(remainder) && $stable(div_by_zero)));

endmodule

// File: tb/tb_booth_divider_seq.sv
// Scoreboard bench for booth_divider_seq: directed cases, then random traffic.
module tb_booth_divider_seq;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  booth_divider_seq #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_in = 0;
  int   n_out = 0;
  bit   rand_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference division, independent of the shift/subtract algorithm.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   qi;
    int   ri;
`ifdef SIGNED_DIV_EN
    int   sa;
    int   sd;
`else
    logic [31:0] ua;
    logic [31:0] ub;
`endif
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
      return e;
    end
`ifdef SIGNED_DIV_EN
    sa = $signed(a);
    sd = $signed(b);
    qi = sa / sd;
    ri = sa % sd;
`else
    ua = 32'(a);
    ub = 32'(b);
    qi = int'(ua / ub);
    ri = int'(ua % ub);
`endif
    e.q   = qi[W-1:0];
    e.r   = ri[W-1:0];
    e.dbz = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic d);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dbz = d;
    return e;
  endfunction

  // Output monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
      n_out++;
    end
  end

  // Present one operand pair; returns one cycle after acceptance (posedge + 1).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    bit got = 1'b0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    else begin
      exp_q.push_back(e);
      n_in++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Cycle index of first out_valid, counting the accept cycle as 0.
  task automatic check_latency(input string tag, input int exp_lat);
    int lat = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    chk(tag, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 2000; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 100 / 7 with a willing consumer
    out_ready = 1'b1;
    send(16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0));
    chk("busy_iter", 32'(busy), 32'd1);
    chk("in_ready_iter", 32'(in_ready), 32'd0);
    check_latency("latency_norm", 18);
    wait_drain();

    // Divide by zero
    send(16'h1234, 16'h0000, mk(16'hFFFF, 16'h1234, 1'b1));
    check_latency("latency_dbz", 2);
    wait_drain();

    // Backpressure: hold DONE for 10 cycles, with ignored in_valid traffic
    out_ready = 1'b0;
    send(16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0));
    check_latency("latency_bp", 18);
    dividend = 16'd999;
    divisor  = 16'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_quotient", 32'(quotient), 32'd14);
      chk("bp_remainder", 32'(remainder), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of ITER
    send(16'd1000, 16'd3, mk(16'd333, 16'd1, 1'b0));
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    exp_q.delete();
    n_in--;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_quotient", 32'(quotient), 32'd0);
    chk("mid_rst_remainder", 32'(remainder), 32'd0);
    chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'd50, 16'd5, mk(16'd10, 16'd0, 1'b0));
    wait_drain();

`ifdef SIGNED_DIV_EN
    send(16'hFFF9, 16'd2, mk(16'hFFFD, 16'hFFFF, 1'b0));
    send(16'd7, 16'hFFFE, mk(16'hFFFD, 16'd1, 1'b0));
    send(16'h8000, 16'hFFFF, mk(16'h8000, 16'd0, 1'b0));
    wait_drain();
`endif

    // Random traffic with in_valid gaps and out_ready throttling
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          a = W'($urandom);
          b = W'($urandom);
          case ($urandom_range(0, 9))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 7));
            2:       b = '1;
            3:       a = 16'h8000;
            default: ;
          endcase
          send(a, b, model(a, b));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("txn_count", 32'(n_out), 32'(n_in));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
